// File: rtl/regfile_2r1w_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_2r1w_param : 2-read/1-write register file, registered reads,       |
// | optional bypass and hardwired-zero entry 0, self-clearing after reset.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_2r1w_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic              busy,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   localparam int              c_depth    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] c_last   = {ADDR_W{1'b1}};
   localparam logic [0:0]      c_st_clear = 1'b0;
   localparam logic [0:0]      c_st_idle  = 1'b1;

   logic [0:0]        r_state;
   logic [0:0]        w_next_state;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [DATA_W-1:0] r_mem [c_depth];
   logic [DATA_W-1:0] r_rd1;
   logic [DATA_W-1:0] r_rd2;
   logic              r_rd_valid;
   logic              w_idle;
   logic              w_rd_ok;
   logic              w_wr_ok;
   logic [DATA_W-1:0] w_rdat1;
   logic [DATA_W-1:0] w_rdat2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_st_clear;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_next_state;
         // Counter parks at zero outside CLEAR so a new clear always starts at entry 0
         r_clr_cnt <= (r_state == c_st_clear && r_clr_cnt != c_last) ? r_clr_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_clear: if (r_clr_cnt == c_last) w_next_state = c_st_idle;
         c_st_idle:  if (clr_req)             w_next_state = c_st_clear;
         default:                             w_next_state = c_st_clear;
      endcase
   end

   always_comb begin
      busy    = (r_state == c_st_clear);
      w_idle  = (r_state == c_st_idle);
      w_rd_ok = w_idle && rd_en;
      w_wr_ok = w_idle && we && !clr_req && !((ZERO_REG != 0) && (wa == '0));
   end

   always_comb begin
      w_rdat1 = r_mem[ra1];
      w_rdat2 = r_mem[ra2];
      if ((BYPASS != 0) && w_wr_ok && (wa == ra1)) w_rdat1 = wd;
      if ((BYPASS != 0) && w_wr_ok && (wa == ra2)) w_rdat2 = wd;
      if ((ZERO_REG != 0) && (ra1 == '0))          w_rdat1 = '0;
      if ((ZERO_REG != 0) && (ra2 == '0))          w_rdat2 = '0;
   end

   // Array carries no reset; the CLEAR state zeroes it one entry per cycle
   always_ff @(posedge clk) begin
      if (busy)         r_mem[r_clr_cnt] <= '0;
      else if (w_wr_ok) r_mem[wa]        <= wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd1      <= '0;
         r_rd2      <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_ok;
         if (w_rd_ok) begin
            r_rd1 <= w_rdat1;
            r_rd2 <= w_rdat2;
         end
      end
   end

   assign rd1      = r_rd1;
   assign rd2      = r_rd2;
   assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_2r1w_param : two instances (ZERO_REG=1/BYPASS=1 and 0/0)        |
// | driven in parallel and checked against an array-based model.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_2r1w_param;

   localparam int c_depth = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_req = 1'b0, rd_en = 1'b0, we = 1'b0;
   logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
   logic [31:0] wd = '0;
   logic        busy_z, valid_z, busy_n, valid_n;
   logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;

   logic [31:0] mem_z [c_depth];
   logic [31:0] mem_n [c_depth];
   int          m_busy;
   logic        exp_busy, exp_valid;
   logic [31:0] e1z, e2z, e1n, e2n;
   int          n_chk = 0;
   int          n_fail = 0;

   regfile_2r1w_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut_z (
      .clk(clk), .rst(rst), .clr_req(clr_req), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
      .we(we), .wa(wa), .wd(wd), .busy(busy_z), .rd_valid(valid_z), .rd1(rd1_z), .rd2(rd2_z));

   regfile_2r1w_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut_n (
      .clk(clk), .rst(rst), .clr_req(clr_req), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
      .we(we), .wa(wa), .wd(wd), .busy(busy_n), .rd_valid(valid_n), .rd1(rd1_n), .rd2(rd2_n));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic m_reset();
      m_busy    = c_depth;
      exp_busy  = 1'b1;
      exp_valid = 1'b0;
      e1z = '0; e2z = '0; e1n = '0; e2n = '0;
      for (int i = 0; i < c_depth; i++) begin
         mem_z[i] = '0;
         mem_n[i] = '0;
      end
   endtask

   // Drive one cycle of inputs and advance the reference model across the edge
   task automatic step(input logic c, input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic w, input logic [4:0] wad, input logic [31:0] wdt);
      logic wr_z, wr_n;
      @(negedge clk);
      clr_req = c; rd_en = r; ra1 = a1; ra2 = a2; we = w; wa = wad; wd = wdt;
      @(posedge clk);
      if (m_busy > 0) begin
         m_busy--;
         exp_valid = 1'b0;
      end else begin
         wr_n = w && !c;
         wr_z = wr_n && (wad != 5'd0);
         exp_valid = r;
         if (r) begin
            e1z = (a1 == 5'd0) ? 32'd0 : (wr_z && wad == a1) ? wdt : mem_z[a1];
            e2z = (a2 == 5'd0) ? 32'd0 : (wr_z && wad == a2) ? wdt : mem_z[a2];
            e1n = mem_n[a1];
            e2n = mem_n[a2];
         end
         if (wr_z) mem_z[wad] = wdt;
         if (wr_n) mem_n[wad] = wdt;
         if (c) begin
            m_busy = c_depth;
            for (int i = 0; i < c_depth; i++) begin
               mem_z[i] = '0;
               mem_n[i] = '0;
            end
         end
      end
      exp_busy = (m_busy > 0);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_reset();
      int cnt;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (busy_z !== 1'b1 || valid_z !== 1'b0) begin n_fail++;
         $display("FAIL reset_ctrl: busy=%b valid=%b required busy=1 valid=0", busy_z, valid_z); end
      n_chk++; if (rd1_z !== 32'd0 || rd2_z !== 32'd0) begin n_fail++;
         $display("FAIL reset_data: rd1=%h rd2=%h required 0", rd1_z, rd2_z); end
      rst = 1'b0;
      m_reset();
      cnt = 0;
      for (int i = 0; i < 40 && busy_z === 1'b1; i++) begin idle(); cnt++; end
      n_chk++; if (cnt != 32) begin n_fail++;
         $display("FAIL reset_busy_len: %0d cycles required 32", cnt); end
      for (int a = 0; a < c_depth; a++) begin
         step(1'b0, 1'b1, 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'd0);
         n_chk++; if (rd1_z !== 32'd0 || rd2_z !== 32'd0 || rd1_n !== 32'd0 || valid_z !== 1'b1) begin
            n_fail++;
            $display("FAIL post_clear_read a=%0d: rd1=%h rd2=%h rd1n=%h valid=%b required 0/0/0/1",
                     a, rd1_z, rd2_z, rd1_n, valid_z);
         end
      end
   endtask

   task automatic test_write_read();
      step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
      n_chk++; if (valid_z !== 1'b0) begin n_fail++;
         $display("FAIL wr_no_valid: valid=%b required 0", valid_z); end
      step(1'b0, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
      n_chk++; if (valid_z !== 1'b1 || rd1_z !== 32'hDEADBEEF || rd2_z !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL read_r5: valid=%b rd1=%h rd2=%h required 1 deadbeef deadbeef", valid_z, rd1_z, rd2_z);
      end
      idle();
      n_chk++; if (valid_z !== 1'b0 || rd1_z !== 32'hDEADBEEF) begin n_fail++;
         $display("FAIL read_hold: valid=%b rd1=%h required 0 deadbeef", valid_z, rd1_z); end
   endtask

   task automatic test_bypass();
      step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'hAAAA0000);
      step(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678);
      n_chk++; if (rd1_z !== 32'h12345678 || rd2_z !== 32'h12345678) begin n_fail++;
         $display("FAIL bypass_on: rd1=%h rd2=%h required 12345678", rd1_z, rd2_z); end
      n_chk++; if (rd1_n !== 32'hAAAA0000) begin n_fail++;
         $display("FAIL bypass_off: rd1=%h required aaaa0000", rd1_n); end
      step(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0);
      n_chk++; if (rd1_z !== 32'h12345678 || rd1_n !== 32'h12345678) begin n_fail++;
         $display("FAIL after_bypass: rd1=%h rd1n=%h required 12345678", rd1_z, rd1_n); end
   endtask

   task automatic test_zero_reg();
      step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
      step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
      n_chk++; if (rd1_z !== 32'd0 || rd2_z !== 32'd0) begin n_fail++;
         $display("FAIL zero_reg: rd1=%h rd2=%h required 0", rd1_z, rd2_z); end
      n_chk++; if (rd1_n !== 32'hFFFFFFFF) begin n_fail++;
         $display("FAIL r0_ordinary: rd1=%h required ffffffff", rd1_n); end
      step(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'h5A5A5A5A);
      n_chk++; if (rd1_z !== 32'd0) begin n_fail++;
         $display("FAIL zero_reg_bypass: rd1=%h required 0", rd1_z); end
   endtask

   task automatic test_clear_req();
      int cnt;
      for (int i = 1; i < c_depth; i++)
         step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'h1000_0000 | 32'(i));
      step(1'b0, 1'b1, 5'd3, 5'd31, 1'b0, 5'd0, 32'd0);
      n_chk++; if (rd1_z !== 32'h1000_0003 || rd2_z !== 32'h1000_001F) begin n_fail++;
         $display("FAIL fill_read: rd1=%h rd2=%h required 10000003 1000001f", rd1_z, rd2_z); end
      step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hCAFEF00D);
      cnt = 0;
      for (int i = 0; i < 40 && busy_z === 1'b1; i++) begin idle(); cnt++; end
      n_chk++; if (cnt != 32) begin n_fail++;
         $display("FAIL clr_busy_len: %0d cycles required 32", cnt); end
      for (int a = 0; a < c_depth; a++) begin
         step(1'b0, 1'b1, 5'(a), 5'(a), 1'b0, 5'd0, 32'd0);
         n_chk++; if (rd1_z !== 32'd0 || rd1_n !== 32'd0 || rd2_n !== 32'd0) begin n_fail++;
            $display("FAIL clr_read a=%0d: rd1=%h rd1n=%h rd2n=%h required 0", a, rd1_z, rd1_n, rd2_n);
         end
      end
   endtask

   task automatic test_rst_mid_clear();
      int cnt;
      step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h0BADF00D);
      step(1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0);
      step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
      repeat (10) idle();
      #2 rst = 1'b1;
      #1;
      n_chk++; if (rd1_z !== 32'd0 || rd2_z !== 32'd0 || valid_z !== 1'b0 || busy_z !== 1'b1) begin
         n_fail++;
         $display("FAIL async_rst: rd1=%h rd2=%h valid=%b busy=%b required 0 0 0 1",
                  rd1_z, rd2_z, valid_z, busy_z);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      m_reset();
      cnt = 0;
      for (int i = 0; i < 40 && busy_z === 1'b1; i++) begin idle(); cnt++; end
      n_chk++; if (cnt != 32) begin n_fail++;
         $display("FAIL rst_busy_len: %0d cycles required 32", cnt); end
      n_chk++; if (rd1_z !== 32'd0 || rd2_z !== 32'd0 || valid_z !== 1'b0) begin n_fail++;
         $display("FAIL rst_outputs: rd1=%h rd2=%h valid=%b required 0", rd1_z, rd2_z, valid_z); end
   endtask

   task automatic test_random();
      logic       c, r, w;
      logic [4:0] a1, a2, wad;
      for (int n = 0; n < 600; n++) begin
         c   = ($urandom_range(0, 59) == 0);
         r   = $urandom_range(0, 1) == 1;
         w   = $urandom_range(0, 9) < 6;
         wad = 5'($urandom_range(0, 31));
         a1  = ($urandom_range(0, 2) == 0) ? wad : 5'($urandom_range(0, 31));
         a2  = ($urandom_range(0, 2) == 0) ? wad : 5'($urandom_range(0, 31));
         step(c, r, a1, a2, w, wad, $urandom);
         n_chk++; if (busy_z !== exp_busy || busy_n !== exp_busy) begin n_fail++;
            $display("FAIL rnd_busy n=%0d: %b/%b required %b", n, busy_z, busy_n, exp_busy); end
         n_chk++; if (valid_z !== exp_valid || valid_n !== exp_valid) begin n_fail++;
            $display("FAIL rnd_valid n=%0d: %b/%b required %b", n, valid_z, valid_n, exp_valid); end
         n_chk++; if (rd1_z !== e1z || rd2_z !== e2z) begin n_fail++;
            $display("FAIL rnd_data_z n=%0d: rd1=%h rd2=%h required %h %h", n, rd1_z, rd2_z, e1z, e2z); end
         n_chk++; if (rd1_n !== e1n || rd2_n !== e2n) begin n_fail++;
            $display("FAIL rnd_data_n n=%0d: rd1=%h rd2=%h required %h %h", n, rd1_n, rd2_n, e1n, e2n); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_clear_req();
      test_rst_mid_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
